// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: op codes, flag bit positions and
// the buffered-entry layout carried from accept to retirement.
package alu_pkg;

    localparam int ALU_DW = 8;
    localparam int ALU_RW = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_NOR  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_RSH  = 3'b101,
        ALU_PASS = 3'b110,
        ALU_RSV  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [ALU_DW-1:0] result;
        logic [ALU_RW-1:0] dest;
        logic [1:0]        flags;
        logic              writes_reg;
        logic              sets_flags;
    } alu_entry_t;

    function automatic logic sets_flags(input alu_op_e op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_NOR, ALU_AND, ALU_XOR: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_flag_stage_core.sv
// Combinational ALU: result, carry/zero and write-class decode for one op.
module alu_core
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW
) (
    input  alu_op_e         op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   result,
    output logic            carry,
    output logic            zero,
    output logic            writes_reg,
    output logic            flag_set
);

    logic [DW:0] sum_s;

    // Op decode and arithmetic; SUB carry is the inverted borrow.
    always_comb begin
        sum_s  = {(DW+1){1'b0}};
        result = {DW{1'b0}};
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                sum_s  = {1'b0, a} + {1'b0, b};
                result = sum_s[DW-1:0];
                carry  = sum_s[DW];
            end
            ALU_SUB: begin
                sum_s  = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
                result = sum_s[DW-1:0];
                carry  = sum_s[DW];
            end
            ALU_NOR:  result = ~(a | b);
            ALU_AND:  result = a & b;
            ALU_XOR:  result = a ^ b;
            ALU_RSH:  result = {1'b0, b[DW-1:1]};
            ALU_PASS: result = b;
            default:  result = {DW{1'b0}};
        endcase
    end

    assign zero       = (result == {DW{1'b0}});
    assign writes_reg = (op != ALU_RSV);
    assign flag_set   = sets_flags(op);

endmodule

// File: rtl/alu_flag_stage.sv
// Registered ALU execute stage with a 2-entry output buffer that drives the
// register-file write and the condition-flag register write at retirement.
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int RW = ALU_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [RW-1:0] dest,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic [RW-1:0] out_dest,
    output logic          reg_we,
    output logic [1:0]    flag_din,
    output logic          flag_we
);

    alu_entry_t    mem_r [2];
    logic          rd_ptr_r;
    logic          wr_ptr_r;
    logic [1:0]    count_r;

    logic [DW-1:0] core_result_s;
    logic          core_carry_s;
    logic          core_zero_s;
    logic          core_writes_reg_s;
    logic          core_flag_set_s;
    alu_entry_t    new_entry_s;
    alu_entry_t    head_s;
    logic          accept_s;
    logic          retire_s;

    alu_core #(.DW(DW)) u_core (
        .op         (alu_op_e'(op)),
        .a          (a),
        .b          (b),
        .result     (core_result_s),
        .carry      (core_carry_s),
        .zero       (core_zero_s),
        .writes_reg (core_writes_reg_s),
        .flag_set   (core_flag_set_s)
    );

    // Pack the freshly computed op into a buffer entry.
    always_comb begin
        new_entry_s                = '0;
        new_entry_s.result         = core_result_s;
        new_entry_s.dest           = dest;
        new_entry_s.flags[FLAG_Z]  = core_zero_s;
        new_entry_s.flags[FLAG_C]  = core_carry_s;
        new_entry_s.writes_reg     = core_writes_reg_s;
        new_entry_s.sets_flags     = core_flag_set_s;
    end

    assign in_ready  = (count_r < 2'd2) && !flush;
    assign out_valid = (count_r != 2'd0) && !flush;
    assign accept_s  = in_valid && in_ready;
    assign retire_s  = out_valid && out_ready;
    assign head_s    = mem_r[rd_ptr_r];

    // Buffer storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= new_entry_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (retire_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({accept_s, retire_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation and retirement strobes, all zero when no head is valid.
    always_comb begin
        result   = {DW{1'b0}};
        out_dest = {RW{1'b0}};
        flag_din = 2'b00;
        reg_we   = 1'b0;
        flag_we  = 1'b0;
        if (out_valid) begin
            result   = head_s.result;
            out_dest = head_s.dest;
            flag_din = head_s.flags;
            reg_we   = retire_s && head_s.writes_reg && (head_s.dest != {RW{1'b0}});
            flag_we  = retire_s && head_s.sets_flags;
        end else begin
            reg_we   = 1'b0;
            flag_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage: driver pushes model expectations on
// accept, an independent monitor pops and compares on every retirement.
module tb_alu_flag_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] dest;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] out_dest;
    logic       reg_we;
    logic [1:0] flag_din;
    logic       flag_we;

    typedef struct {
        int result;
        int dest;
        int flags;
        bit reg_we;
        bit flag_we;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    alu_flag_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .dest      (dest),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_dest  (out_dest),
        .reg_we    (reg_we),
        .flag_din  (flag_din),
        .flag_we   (flag_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the op table using integer arithmetic.
    function automatic exp_t model(input int opc, input int av, input int bv, input int d);
        exp_t e;
        int   r;
        bit   c;
        c = 1'b0;
        case (opc)
            0: begin r = (av + bv) % 256; c = (av + bv) > 255; end
            1: begin r = (av - bv + 256) % 256; c = (av >= bv); end
            2: r = 255 - (av | bv);
            3: r = av & bv;
            4: r = av ^ bv;
            5: r = bv / 2;
            6: r = bv;
            default: r = 0;
        endcase
        e.result  = r;
        e.dest    = d;
        e.flags   = (c ? 2 : 0) + ((r == 0) ? 1 : 0);
        e.flag_we = (opc <= 4);
        e.reg_we  = (opc != 7) && (d != 0);
        return e;
    endfunction

    task automatic cycle(input bit iv, input int opc, input int av, input int bv,
                         input int d, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        op        = 3'(opc);
        a         = 8'(av);
        b         = 8'(bv);
        dest      = 4'(d);
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("in_ready", int'(in_ready), int'(sb.size() < 2 && !fl));
        chk("out_valid", int'(out_valid), int'(sb.size() != 0 && !fl));
        if (fl) begin
            sb.delete();
        end else if (iv && sb.size() < 2) begin
            sb.push_back(model(opc, av, bv, d));
        end
    endtask

    // Monitor: compare every retirement against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", int'(result), e.result);
                        chk("out_dest", int'(out_dest), e.dest);
                        chk("reg_we", int'(reg_we), int'(e.reg_we));
                        chk("flag_we", int'(flag_we), int'(e.flag_we));
                        if (e.flag_we) chk("flag_din", int'(flag_din), e.flags);
                    end
                end else begin
                    chk("idle_reg_we", int'(reg_we), 0);
                    chk("idle_flag_we", int'(flag_we), 0);
                    if (!out_valid) begin
                        chk("idle_result", int'(result), 0);
                        chk("idle_flag_din", int'(flag_din), 0);
                        chk("idle_out_dest", int'(out_dest), 0);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
        dest = 4'd0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flag_we", int'(flag_we), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed ops
        cycle(1'b1, 0, 200, 56, 3, 1'b1, 1'b0);
        cycle(1'b1, 1, 5, 7, 1, 1'b1, 1'b0);
        cycle(1'b1, 1, 7, 7, 1, 1'b1, 1'b0);
        cycle(1'b1, 5, 9, 8'h81, 2, 1'b1, 1'b0);
        cycle(1'b1, 6, 9, 8'h33, 0, 1'b1, 1'b0);
        cycle(1'b1, 7, 1, 2, 5, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);

        // Backpressure: third op must wait until writeback drains
        cycle(1'b1, 0, 10, 20, 4, 1'b0, 1'b0);
        cycle(1'b1, 5, 0, 6, 5, 1'b0, 1'b0);
        cycle(1'b1, 4, 15, 15, 6, 1'b0, 1'b0);
        cycle(1'b1, 4, 15, 15, 6, 1'b0, 1'b0);
        cycle(1'b1, 4, 15, 15, 6, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);

        // Flush with two buffered ops and an incoming op
        cycle(1'b1, 0, 1, 1, 7, 1'b0, 1'b0);
        cycle(1'b1, 1, 9, 1, 8, 1'b0, 1'b0);
        cycle(1'b1, 0, 3, 3, 9, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with a full buffer
        cycle(1'b1, 0, 100, 1, 10, 1'b0, 1'b0);
        cycle(1'b1, 2, 0, 0, 11, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_result", int'(result), 0);
        chk("arst_out_dest", int'(out_dest), 0);
        chk("arst_flag_din", int'(flag_din), 0);
        chk("arst_reg_we", int'(reg_we), 0);
        chk("arst_flag_we", int'(flag_we), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        end
        cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("drain_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
